// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer driving a 3-to-8 decoder: walks the enabled positions of a mask,
// holding each for a programmable dwell with optional blanking gaps in between.
module decoder_scan_ctrl #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               pass_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    localparam logic       HAS_BLANK  = (BLANK_CYCLES > 0);
    localparam logic [7:0] BLANK_LAST = (BLANK_CYCLES > 0) ? 8'(BLANK_CYCLES - 1) : 8'd0;

    state_e             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               pass_done_q, pass_done_d;
    logic               mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [7:0]         blank_cnt_q, blank_cnt_d;

    logic               dwell_last;
    logic [2:0]         next_pos;
    logic               pass_end;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // Smallest positive offset wins; a lone bit maps back onto itself.
    function automatic logic [2:0] next_bit(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] idx;
        next_bit = cur;
        for (int off = 7; off >= 1; off--) begin
            idx = cur + 3'(off);
            if (m[idx]) next_bit = idx;
        end
    endfunction

    assign dwell_last = (dwell_q == '0) || (dwell_cnt_q == dwell_q - 1'b1);
    assign next_pos   = next_bit(mask_q, sel_q);
    assign pass_end   = (next_pos <= sel_q);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        pass_done_d = 1'b0;
        mode_d      = mode_q;
        dwell_d     = dwell_q;
        mask_d      = mask_q;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop && (mask != 8'd0)) begin
                    mode_d      = mode;
                    dwell_d     = dwell;
                    mask_d      = mask;
                    sel_d       = lowest_bit(mask);
                    dwell_cnt_d = '0;
                    blank_cnt_d = 8'd0;
                    state_d     = HAS_BLANK ? ST_BLANK : ST_DWELL;
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q == BLANK_LAST) begin
                    dwell_cnt_d = '0;
                    state_d     = ST_DWELL;
                end else begin
                    blank_cnt_d = blank_cnt_q + 8'd1;
                end
            end
            ST_DWELL: begin
                if (dwell_last) begin
                    pass_done_d = pass_end;
                    if (pass_end && mode_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        sel_d       = next_pos;
                        dwell_cnt_d = '0;
                        blank_cnt_d = 8'd0;
                        state_d     = HAS_BLANK ? ST_BLANK : ST_DWELL;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides every transition above; sel keeps its last value.
        if (stop) begin
            state_d     = ST_IDLE;
            sel_d       = sel_q;
            pass_done_d = 1'b0;
        end

        en_d   = (state_d == ST_DWELL);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 3'd0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
            mode_q      <= 1'b0;
            dwell_q     <= '0;
            mask_q      <= 8'd0;
            dwell_cnt_q <= '0;
            blank_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            pass_done_q <= pass_done_d;
            mode_q      <= mode_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign sel       = sel_q;
    assign en        = en_q;
    assign busy      = busy_q;
    assign pass_done = pass_done_q;

endmodule
